// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display manager: register map, scan
// states, segment bit positions and the hex glyph table.
package seg_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DP     = 3'd1;
    localparam logic [2:0] ADDR_BLANK  = 3'd2;
    localparam logic [2:0] ADDR_CTRL   = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;
    localparam logic [2:0] ADDR_BRIGHT = 3'd5;
    localparam logic [2:0] ADDR_NONE   = 3'd7;

    localparam logic SCAN_DEAD = 1'b0;
    localparam logic SCAN_ON   = 1'b1;

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_LZS    = 1;

    // Segments a..g for glyphs 0-9, A, b, C, d, E, F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_display_manager_if.sv
// AHB-Lite slave-side signal bundle for the display manager.
interface seg_display_manager_if;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HREADY;
    logic        HSEL;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HRDATA;
    logic        HREADYOUT;

    modport master (
        output HADDR, HWDATA, HWRITE, HREADY, HSEL, HSIZE, HTRANS,
        input  HRDATA, HREADYOUT
    );

    modport slave (
        input  HADDR, HWDATA, HWRITE, HREADY, HSEL, HSIZE, HTRANS,
        output HRDATA, HREADYOUT
    );
endinterface

// File: rtl/seg_hex_decoder.sv
// Nibble + decimal point to active-high segment pattern; dark forces all off.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       dark,
    output logic [7:0] seg
);

    always_comb begin
        seg = '0;
        if (!dark) begin
            seg[SEG_G:SEG_A] = HEX_SEG[nibble];
            seg[SEG_DP]      = dp;
        end
    end

endmodule

// File: rtl/seg_display_manager.sv
// AHB-Lite 4-digit multiplexed 7-segment display manager with frame-aligned
// shadow commit. Optional SEG_BRIGHTNESS_EN adds a BRIGHT duty register.
module seg_display_manager
    import seg_pkg::*;
#(
    parameter int unsigned DIGIT_TICKS = 120,
    parameter int unsigned DEAD_TICKS  = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    seg_display_manager_if.slave bus,
    output logic [7:0]           Seg,
    output logic [3:0]           nDigit
);

    localparam int unsigned MAX_TICKS = (DIGIT_TICKS > DEAD_TICKS) ? DIGIT_TICKS : DEAD_TICKS;
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_TICKS - 1);
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(DIGIT_TICKS - 1);

    logic             xfer;
    logic             write_q;
    logic [2:0]       addr_q;
    logic             wr_data, wr_dp, wr_blank, wr_ctrl, wr_shadow;
    logic [15:0]      data_sh, data_act;
    logic [3:0]       dp_sh, dp_act, blank_sh, blank_act;
    logic [1:0]       ctrl_q;
    logic             pending_q, pending_d;
    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_q, digit_d;
    logic             frame_end, commit;
    logic [3:0]       nibble;
    logic             lead_zero, bright_ok, lit, dark;
    logic [7:0]       seg_d, seg_q;
    logic [3:0]       ndigit_d, ndigit_q;
    logic [31:0]      rdata;
    logic             unused_bits;

    assign unused_bits = ^{bus.HSIZE, bus.HADDR[31:5], bus.HADDR[1:0], bus.HWDATA[31:16]};

    // Address phase capture; idle cycles park on an unmapped address
    assign xfer = bus.HSEL && bus.HREADY && (bus.HTRANS != 2'b00);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            write_q <= 1'b0;
            addr_q  <= ADDR_NONE;
        end else begin
            write_q <= xfer && bus.HWRITE;
            addr_q  <= xfer ? bus.HADDR[4:2] : ADDR_NONE;
        end
    end

    assign wr_data   = write_q && (addr_q == ADDR_DATA);
    assign wr_dp     = write_q && (addr_q == ADDR_DP);
    assign wr_blank  = write_q && (addr_q == ADDR_BLANK);
    assign wr_ctrl   = write_q && (addr_q == ADDR_CTRL);
    assign wr_shadow = wr_data || wr_dp || wr_blank;

`ifdef SEG_BRIGHTNESS_EN
    logic [2:0] bright_q;
    logic       wr_bright;

    assign wr_bright = write_q && (addr_q == ADDR_BRIGHT);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            bright_q <= 3'd7;
        end else if (wr_bright) begin
            bright_q <= bus.HWDATA[2:0];
        end
    end

    assign bright_ok = 32'(cnt_q) < (((32'(bright_q) + 32'd1) * DIGIT_TICKS) / 32'd8);
`else
    assign bright_ok = 1'b1;
`endif

    // Scan sequencing: DEAD then ON per digit, digit0..3, frame ends leaving digit3
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        digit_d   = digit_q;
        frame_end = 1'b0;
        if (state_q == SCAN_DEAD) begin
            if (cnt_q == DEAD_LAST) begin
                state_d = SCAN_ON;
                cnt_d   = '0;
            end
        end else if (cnt_q == ON_LAST) begin
            state_d   = SCAN_DEAD;
            cnt_d     = '0;
            digit_d   = digit_q + 2'd1;
            frame_end = (digit_q == 2'd3);
        end
    end

    assign commit = frame_end && pending_q;
    // A write landing on the commit cycle keeps Pending so it shows next frame
    assign pending_d = (pending_q && !commit) || wr_shadow;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q   <= SCAN_DEAD;
            cnt_q     <= '0;
            digit_q   <= 2'd0;
            pending_q <= 1'b0;
            data_sh   <= '0;
            dp_sh     <= '0;
            blank_sh  <= '0;
            data_act  <= '0;
            dp_act    <= '0;
            blank_act <= '0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            pending_q <= pending_d;
            if (commit) begin
                data_act  <= data_sh;
                dp_act    <= dp_sh;
                blank_act <= blank_sh;
            end
            if (wr_data)  data_sh  <= bus.HWDATA[15:0];
            if (wr_dp)    dp_sh    <= bus.HWDATA[3:0];
            if (wr_blank) blank_sh <= bus.HWDATA[3:0];
            if (wr_ctrl)  ctrl_q   <= bus.HWDATA[1:0];
        end
    end

    assign nibble = data_act[{digit_q, 2'b00} +: 4];

    always_comb begin
        lead_zero = 1'b0;
        case (digit_q)
            2'd3:    lead_zero = (data_act[15:12] == 4'd0);
            2'd2:    lead_zero = (data_act[15:8] == 8'd0);
            2'd1:    lead_zero = (data_act[15:4] == 12'd0);
            default: lead_zero = 1'b0;
        endcase
    end

    assign lit = (state_q == SCAN_ON) && ctrl_q[CTRL_ENABLE] && !blank_act[digit_q] &&
                 !(ctrl_q[CTRL_LZS] && lead_zero) && bright_ok;
    assign dark     = !lit;
    assign ndigit_d = lit ? ~(4'b0001 << digit_q) : 4'hF;

    seg_hex_decoder u_hex_decoder (
        .nibble (nibble),
        .dp     (dp_act[digit_q]),
        .dark   (dark),
        .seg    (seg_d)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            seg_q    <= 8'h00;
            ndigit_q <= 4'hF;
        end else begin
            seg_q    <= seg_d;
            ndigit_q <= ndigit_d;
        end
    end

    assign Seg    = seg_q;
    assign nDigit = ndigit_q;

    always_comb begin
        rdata = '0;
        if (!write_q) begin
            case (addr_q)
                ADDR_DATA:   rdata[15:0] = data_sh;
                ADDR_DP:     rdata[3:0]  = dp_sh;
                ADDR_BLANK:  rdata[3:0]  = blank_sh;
                ADDR_CTRL:   rdata[1:0]  = ctrl_q;
                ADDR_STATUS: rdata[2:0]  = {digit_q, pending_q};
`ifdef SEG_BRIGHTNESS_EN
                ADDR_BRIGHT: rdata[2:0]  = bright_q;
`else
                ADDR_BRIGHT: rdata       = '0;
`endif
                default:     rdata       = '0;
            endcase
        end
    end

    assign bus.HRDATA    = rdata;
    assign bus.HREADYOUT = 1'b1;

endmodule

// File: tb/tb_seg_display_manager.sv
// Directed + randomized bench for seg_display_manager against a frame-time
// model of the display (SEG_BRIGHTNESS_EN follows the DUT build).
module tb_seg_display_manager;

    localparam int DIGIT_TICKS = 120;
    localparam int DEAD_TICKS  = 8;
    localparam int SLOT        = DIGIT_TICKS + DEAD_TICKS;
    localparam int FRAME       = 4 * SLOT;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [7:0] Seg;
    logic [3:0] nDigit;

    seg_display_manager_if bus ();

    seg_display_manager #(
        .DIGIT_TICKS (DIGIT_TICKS),
        .DEAD_TICKS  (DEAD_TICKS)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus),
        .Seg    (Seg),
        .nDigit (nDigit)
    );

    always #5 HCLK = ~HCLK;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] hex_tab [16];

    // Reference state: fcnt is the scan position in cycles since reset release
    int          fcnt;
    logic [15:0] m_data_sh, m_data;
    logic [3:0]  m_dp_sh, m_dp, m_bl_sh, m_bl;
    logic [1:0]  m_ctrl;
    logic [2:0]  m_bright;
    bit          m_pend;
    bit          mw_valid;
    int          mw_addr;
    logic [31:0] mw_data;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s at scan pos %0d: observed %h expected %h", tag, fcnt, got, want);
        end
    endtask

    task automatic model_expect(output logic [7:0] s, output logic [3:0] nd);
        int         p;
        int         d;
        int         q;
        logic [1:0] dsel;
        logic [3:0] nib;
        bit         lit;
        p    = fcnt % FRAME;
        d    = p / SLOT;
        q    = p % SLOT;
        dsel = 2'(d);
        nib  = m_data[{dsel, 2'b00} +: 4];
        lit  = (q >= DEAD_TICKS) && m_ctrl[0] && !m_bl[dsel] &&
               !(m_ctrl[1] && d > 0 && (m_data >> (4 * d)) == 16'd0);
`ifdef SEG_BRIGHTNESS_EN
        lit = lit && ((q - DEAD_TICKS) < ((int'(m_bright) + 1) * DIGIT_TICKS) / 8);
`endif
        s  = lit ? (hex_tab[nib] | (m_dp[dsel] ? 8'h80 : 8'h00)) : 8'h00;
        nd = lit ? ~(4'b0001 << dsel) : 4'hF;
    endtask

    function automatic logic [31:0] model_read(input int addr);
        case (addr)
            0:       return {16'd0, m_data_sh};
            1:       return {28'd0, m_dp_sh};
            2:       return {28'd0, m_bl_sh};
            3:       return {30'd0, m_ctrl};
            4:       return {29'd0, 2'((fcnt % FRAME) / SLOT), m_pend};
`ifdef SEG_BRIGHTNESS_EN
            5:       return {29'd0, m_bright};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        fcnt      = 0;
        m_data_sh = '0; m_data = '0;
        m_dp_sh   = '0; m_dp   = '0;
        m_bl_sh   = '0; m_bl   = '0;
        m_ctrl    = '0;
        m_bright  = 3'd7;
        m_pend    = 0;
        mw_valid  = 0;
    endtask

    // One clock: predict outputs, advance the model, then compare the display
    task automatic tick();
        logic [7:0] es;
        logic [3:0] en;
        model_expect(es, en);
        @(posedge HCLK);
        if ((fcnt % FRAME) == FRAME - 1 && m_pend) begin
            m_data = m_data_sh;
            m_dp   = m_dp_sh;
            m_bl   = m_bl_sh;
            m_pend = 0;
        end
        if (mw_valid) begin
            case (mw_addr)
                0: begin m_data_sh = mw_data[15:0]; m_pend = 1; end
                1: begin m_dp_sh   = mw_data[3:0];  m_pend = 1; end
                2: begin m_bl_sh   = mw_data[3:0];  m_pend = 1; end
                3: m_ctrl = mw_data[1:0];
`ifdef SEG_BRIGHTNESS_EN
                5: m_bright = mw_data[2:0];
`endif
                default: ;
            endcase
            mw_valid = 0;
        end
        fcnt++;
        #1;
        check32("seg", {24'd0, Seg}, {24'd0, es});
        check32("ndigit", {28'd0, nDigit}, {28'd0, en});
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_to_frame();
        for (int i = 0; i < FRAME && (fcnt % FRAME) != 0; i++) tick();
    endtask

    task automatic bus_write(input int addr, input logic [31:0] data);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b1;
        bus.HADDR  = 32'(addr) << 2;
        tick();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HWDATA = data;
        check32("hrdata_wr_phase", bus.HRDATA, 32'd0);
        mw_valid = 1;
        mw_addr  = addr;
        mw_data  = data;
        tick();
    endtask

    task automatic bus_read(input int addr);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b0;
        bus.HADDR  = 32'(addr) << 2;
        tick();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        check32($sformatf("read_a%0d", addr), bus.HRDATA, model_read(addr));
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_seg"}, {24'd0, Seg}, 32'h0);
        check32({tag, "_ndigit"}, {28'd0, nDigit}, 32'hF);
        check32({tag, "_hrdata"}, bus.HRDATA, 32'h0);
        check32({tag, "_hreadyout"}, {31'd0, bus.HREADYOUT}, 32'h1);
    endtask

    initial begin
        int          a;
        logic [31:0] d;
        hex_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
        bus.HADDR  = '0;
        bus.HWDATA = '0;
        bus.HWRITE = 1'b0;
        bus.HREADY = 1'b1;
        bus.HSEL   = 1'b0;
        bus.HSIZE  = 3'b010;
        bus.HTRANS = 2'b00;
        model_reset();
        HRESET = 1'b1;
        #1;
        check_reset_outputs("por");
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        bus_read(4);

        // Basic count-up display, Pending held until frame end
        bus_write(3, 32'h1);
        bus_write(0, 32'h1234);
        bus_read(4);
        run_to_frame();
        run(FRAME);
        bus_read(4);

        // Leading-zero suppression on and off
        bus_write(0, 32'h0007);
        bus_write(3, 32'h3);
        run_to_frame();
        run(FRAME);
        bus_write(3, 32'h1);
        run(FRAME);

        // Shadow update mid-frame stays hidden until commit
        bus_write(0, 32'h8888);
        run_to_frame();
        run(200);
        bus_write(0, 32'hFFFF);
        bus_read(4);
        run_to_frame();
        run(3);
        bus_read(4);
        bus_read(0);
        run(FRAME);

        // Blanking and decimal points
        bus_write(2, 32'h5);
        bus_write(1, 32'h2);
        bus_write(0, 32'h0);
        run_to_frame();
        run(FRAME);

        // Randomized register traffic, including writes near the commit edge
        for (int i = 0; i < 24; i++) begin
            a = $urandom_range(0, 7);
            d = $urandom;
            if (a == 3) d[0] = ($urandom_range(0, 3) != 0);
            if (i % 6 == 5) begin
                for (int k = 0; k < FRAME && (fcnt % FRAME) != FRAME - 3; k++) tick();
            end
            bus_write(a, d);
            run($urandom_range(0, 300));
            bus_read($urandom_range(0, 7));
        end

        // Asynchronous reset while digit 2 is lit
        bus_write(3, 32'h1);
        bus_write(2, 32'h0);
        bus_write(0, 32'h4321);
        run_to_frame();
        run(2 * SLOT + DEAD_TICKS + 20);
        bus_read(4);
        HRESET = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("mid_reset");
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        bus_read(4);
        run(SLOT);

        // Brightness register
        bus_write(3, 32'h1);
        bus_write(0, 32'hABCD);
        bus_write(5, 32'h3);
        bus_read(5);
        run_to_frame();
        run(FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
